// File: rtl/regfile_sequencer.sv
// Command sequencer for a write-enable-less register file: turns LOAD/MOV/READ/SWAP
// commands into per-cycle read/write/din drive, recirculating on every non-write cycle.
module regfile_sequencer #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rs,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [AW-1:0]    rf_read,
  output logic [AW-1:0]    rf_write,
  output logic [WIDTH-1:0] rf_din,
  input  logic [WIDTH-1:0] rf_dout
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] EXEC  = 3'd1;
  localparam logic [2:0] SWAP2 = 3'd2;
  localparam logic [2:0] SWAP3 = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [1:0]       op;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rs;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] temp;
  logic             accept;

  assign cmd_ready = reset && (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Register-file drive and next state; default is recirculate register 0
  always_comb begin
    rf_read    = {AW{1'b0}};
    rf_write   = {AW{1'b0}};
    rf_din     = rf_dout;
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end else begin
          state_next = IDLE;
        end
      end
      EXEC: begin
        case (op)
          OP_LOAD: begin
            rf_read    = rd;
            rf_write   = rd;
            rf_din     = imm;
            state_next = IDLE;
          end
          OP_MOV: begin
            rf_read    = rs;
            rf_write   = rd;
            state_next = IDLE;
          end
          OP_READ: begin
            rf_read    = rs;
            rf_write   = rs;
            state_next = RESP;
          end
          OP_SWAP: begin
            rf_read    = rs;
            rf_write   = rs;
            state_next = SWAP2;
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end
      SWAP2: begin
        rf_read    = rd;
        rf_write   = rs;
        state_next = SWAP3;
      end
      SWAP3: begin
        rf_read    = rd;
        rf_write   = rd;
        rf_din     = temp;
        state_next = IDLE;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, command capture, swap temporary and response registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op        <= 2'b00;
      rd        <= {AW{1'b0}};
      rs        <= {AW{1'b0}};
      imm       <= {WIDTH{1'b0}};
      temp      <= {WIDTH{1'b0}};
      rsp_valid <= 1'b0;
      rsp_data  <= {WIDTH{1'b0}};
    end else begin
      state <= state_next;
      if (accept) begin
        op  <= cmd_op;
        rd  <= cmd_rd;
        rs  <= cmd_rs;
        imm <= cmd_imm;
      end
      if ((state == EXEC) && (op == OP_READ)) begin
        rsp_data  <= rf_dout;
        rsp_valid <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if ((state == EXEC) && (op == OP_SWAP)) begin
        temp <= rf_dout;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 8x8 register file attached.
module tb_regfile_sequencer;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_rd;
  logic [2:0] cmd_rs;
  logic [7:0] cmd_imm;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;
  logic [2:0] rf_read;
  logic [2:0] rf_write;
  logic [7:0] rf_din;
  logic [7:0] rf_dout;

  logic [7:0] regs [8];
  int tests;
  int fails;
  int accepts;

  regfile_sequencer #(.WIDTH(8), .AW(3)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .rf_read(rf_read), .rf_write(rf_write), .rf_din(rf_din),
    .rf_dout(rf_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: loads din into write every edge, clears on reset
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else begin
      regs[rf_write] <= rf_din;
    end
  end
  assign rf_dout = regs[rf_read];

  always @(posedge clock) begin
    if (reset && cmd_valid && cmd_ready) accepts <= accepts + 1;
  end

  task automatic send(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [7:0] imm, output int waits);
    logic got;
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm; cmd_valid = 1'b1;
    waits = 0; got = 1'b0;
    while (!got && waits < 50) begin
      @(negedge clock);
      waits++;
      if (cmd_ready) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL accept_timeout: op=%0d not accepted after %0d cycles", op, waits);
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] rs, input logic [7:0] exp);
    int w, n;
    logic got;
    rsp_ready = 1'b1;
    send(2'b10, 3'd0, rs, 8'h00, w);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clock);
      n++;
      if (rsp_valid) got = 1'b1;
    end
    tests++;
    if (!got || rsp_data !== exp) begin
      fails++;
      $display("FAIL read_r%0d: got valid=%0b data=%h, want valid=1 data=%h", rs, got, rsp_data, exp);
    end
    tests++;
    if (n != 2) begin
      fails++;
      $display("FAIL read_latency: got %0d cycles, want 2", n);
    end
    @(posedge clock); @(negedge clock);
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL read_pulse: rsp_valid=%b after consume, want 0", rsp_valid);
    end
  endtask

  task automatic load(input logic [2:0] rd, input logic [7:0] imm);
    int w;
    send(2'b00, rd, 3'd0, imm, w);
    @(posedge clock); #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (busy) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    tests++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 ||
        rf_read !== 3'd0 || rf_write !== 3'd0 || rf_din !== rf_dout) begin
      fails++;
      $display("FAIL reset_values: ready=%b busy=%b rv=%b rd=%h rfr=%0d rfw=%0d, want 0 0 0 00 0 0",
               cmd_ready, busy, rsp_valid, rsp_data, rf_read, rf_write);
    end
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_load_read();
    int w;
    send(2'b00, 3'd5, 3'd0, 8'hA7, w);
    @(negedge clock);
    tests++;
    if (rf_write !== 3'd5 || rf_din !== 8'hA7) begin
      fails++;
      $display("FAIL load_drive: write=%0d din=%h, want 5 a7", rf_write, rf_din);
    end
    do_read(3'd5, 8'hA7);
    for (int i = 0; i < 8; i++) begin
      if (i != 5) begin
        tests++;
        if (regs[i] !== 8'h00) begin
          fails++;
          $display("FAIL untouched_r%0d: got %h want 00", i, regs[i]);
        end
      end
    end
  endtask

  task automatic test_mov();
    int w;
    load(3'd1, 8'h3C);
    send(2'b01, 3'd6, 3'd1, 8'h00, w);
    do_read(3'd6, 8'h3C);
    do_read(3'd1, 8'h3C);
    load(3'd2, 8'h55);
    send(2'b01, 3'd2, 3'd2, 8'h00, w);
    do_read(3'd2, 8'h55);
  endtask

  task automatic test_swap();
    int w, n;
    load(3'd0, 8'h11);
    load(3'd7, 8'hEE);
    send(2'b11, 3'd7, 3'd0, 8'h00, w);
    count_busy(n);
    tests++;
    if (n != 3) begin
      fails++;
      $display("FAIL swap_busy: busy for %0d cycles, want 3", n);
    end
    do_read(3'd0, 8'hEE);
    do_read(3'd7, 8'h11);
    load(3'd4, 8'h5A);
    send(2'b11, 3'd4, 3'd4, 8'h00, w);
    count_busy(n);
    tests++;
    if (n != 3) begin
      fails++;
      $display("FAIL swap_same_busy: busy for %0d cycles, want 3", n);
    end
    do_read(3'd4, 8'h5A);
  endtask

  task automatic test_backpressure();
    int w;
    load(3'd3, 8'hC3);
    rsp_ready = 1'b0;
    send(2'b10, 3'd0, 3'd3, 8'h00, w);
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hC3 || cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold%0d: rv=%b data=%h ready=%b, want 1 c3 0",
                 i, rsp_valid, rsp_data, cmd_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_release: ready=%b rv=%b, want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int w, a0;
    a0 = accepts;
    send(2'b11, 3'd3, 3'd2, 8'h00, w);
    send(2'b00, 3'd6, 3'd0, 8'h99, w);
    tests++;
    if (w != 4) begin
      fails++;
      $display("FAIL stall_wait: accepted after %0d cycles, want 4", w);
    end
    @(posedge clock); #1;
    tests++;
    if (accepts - a0 != 2) begin
      fails++;
      $display("FAIL stall_accepts: got %0d accepts, want 2", accepts - a0);
    end
    do_read(3'd2, 8'hC3);
    do_read(3'd3, 8'h55);
    do_read(3'd6, 8'h99);
  endtask

  task automatic test_reset_mid_swap();
    int w;
    send(2'b11, 3'd7, 3'd0, 8'h00, w);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rf_write !== 3'd0) begin
      fails++;
      $display("FAIL mid_swap_reset: busy=%b ready=%b rv=%b wr=%0d, want 0 0 0 0",
               busy, cmd_ready, rsp_valid, rf_write);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_ready: ready=%b busy=%b, want 1 0", cmd_ready, busy);
    end
    @(posedge clock); #1;
    load(3'd4, 8'h77);
    do_read(3'd4, 8'h77);
    do_read(3'd0, 8'h00);
  endtask

  initial begin
    tests = 0; fails = 0; accepts = 0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rd = 3'd0; cmd_rs = 3'd0; cmd_imm = 8'h00;
    rsp_ready = 1'b1; reset = 1'b0;
    #1;
    test_reset();
    @(posedge clock); #1;
    test_load_read();
    test_mov();
    test_swap();
    test_backpressure();
    @(posedge clock); #1;
    test_back_to_back();
    test_reset_mid_swap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
